// File: rtl/dkong3_obj_dma_pkg.sv
// ==== dkong3_obj_dma_pkg : shared types/constants for the object-RAM DMA, rev 1.0 ====
`default_nettype none

package dkong3_obj_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REL  = 3'd4
  } dma_state_t;

  localparam int DEFAULT_LEN = 384;
  localparam int OBJ_RAM_AW  = 10;
  localparam int IDX_W       = 10;

  // Bank selects the upper half of the object RAM; the low 9 index bits address within it.
  function automatic logic [OBJ_RAM_AW-1:0] obj_addr(input logic bank, input logic [8:0] idx_lo);
    return {bank, idx_lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dkong3_obj_dma.sv
// ==== dkong3_obj_dma : CPU work RAM -> object RAM block copy over a BUSRQ/BUSAK handshake, rev 1.0 ====
`default_nettype none

module dkong3_obj_dma
  import dkong3_obj_dma_pkg::*;
#(
  parameter int LEN   = DEFAULT_LEN,
  parameter int SRC_W = 16
) (
  input  logic                  I_CLK_12M,
  input  logic                  RST_4L,
  input  logic                  I_START,
  input  logic [SRC_W-1:0]      I_SRC_BASE,
  input  logic                  I_BANK,
  output logic                  O_BUSRQn,
  input  logic                  I_BUSAKn,
  output logic [SRC_W-1:0]      O_SRC_A,
  output logic                  O_SRC_RDn,
  input  logic [7:0]            I_SRC_D,
  output logic [OBJ_RAM_AW-1:0] O_OBJ_DMA_A,
  output logic [7:0]            O_OBJ_DMA_D,
  output logic                  O_OBJ_DMA_CE,
  output logic                  O_BUSY,
  output logic                  O_DONE
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  generate
    if (LEN < 1 || LEN > 512) begin : g_len_chk
      $error("dkong3_obj_dma: LEN must be in 1..512");
    end
  endgenerate

  dma_state_t            r_state;
  logic                  r_armed;
  logic [SRC_W-1:0]      r_base;
  logic                  r_bank;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_busrq_n;
  logic [SRC_W-1:0]      r_src_a;
  logic                  r_src_rd_n;
  logic [OBJ_RAM_AW-1:0] r_obj_a;
  logic [7:0]            r_obj_d;
  logic                  r_obj_ce;
  logic                  r_busy;
  logic                  r_done;

  logic [IDX_W-1:0]      w_idx_inc;
  logic                  w_last;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_last    = (r_idx == LAST_IDX);

  // r_armed blocks a start that coincides with the edge releasing reset.
  always_ff @(posedge I_CLK_12M or negedge RST_4L) begin
    if (!RST_4L) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_base     <= '0;
      r_bank     <= 1'b0;
      r_idx      <= '0;
      r_busrq_n  <= 1'b1;
      r_src_a    <= '0;
      r_src_rd_n <= 1'b1;
      r_obj_a    <= '0;
      r_obj_d    <= '0;
      r_obj_ce   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      r_obj_ce <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (I_START && r_armed) begin
            r_base    <= I_SRC_BASE;
            r_bank    <= I_BANK;
            r_idx     <= '0;
            r_busrq_n <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!I_BUSAKn) begin
            r_src_a    <= r_base + SRC_W'(r_idx);
            r_src_rd_n <= 1'b0;
            r_state    <= ST_RD;
          end
        end
        ST_RD: begin
          r_src_rd_n <= 1'b1;
          r_state    <= I_BUSAKn ? ST_REQ : ST_WR;
        end
        ST_WR: begin
          // Source data is valid in this cycle; it is captured and presented with CE next cycle.
          if (I_BUSAKn) begin
            r_state <= ST_REQ;
          end else begin
            r_obj_ce <= 1'b1;
            r_obj_a  <= obj_addr(r_bank, r_idx[8:0]);
            r_obj_d  <= I_SRC_D;
            r_idx    <= w_idx_inc;
            if (w_last) begin
              r_busrq_n <= 1'b1;
              r_state   <= ST_REL;
            end else begin
              r_src_a    <= r_base + SRC_W'(w_idx_inc);
              r_src_rd_n <= 1'b0;
              r_state    <= ST_RD;
            end
          end
        end
        ST_REL: begin
          if (I_BUSAKn) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busrq_n  <= 1'b1;
          r_src_rd_n <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_BUSRQn     = r_busrq_n;
  assign O_SRC_A      = r_src_a;
  assign O_SRC_RDn    = r_src_rd_n;
  assign O_OBJ_DMA_A  = r_obj_a;
  assign O_OBJ_DMA_D  = r_obj_d;
  assign O_OBJ_DMA_CE = r_obj_ce;
  assign O_BUSY       = r_busy;
  assign O_DONE       = r_done;

endmodule

`default_nettype wire
